fir_ctrl: RTL and testbench

FIR_CTRL -- requirements
Module: fir_ctrl

---
 rtl/fir_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_fir_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_ctrl.sv
// -----------------------------------------------------------------------------
// fir_ctrl
// Sequencer between three ready/valid streams and an external FIR engine.
// Weights are shifted into the FIR with fir_wind. Samples are shifted in with
// fir_load: a full window of NTAPS samples the first time, then one sample per
// result as a sliding window. fir_in_valid is then pulsed for four cycles, the
// FIR result is captured, and the result is offered on the r_* stream.
// Every register updates on the falling edge of clk, which is the FIR's edge.
//
// Optional feature (macro FIR_CTRL_TIMEOUT_EN): bounds the wait for
// fir_out_valid to TMO cycles and raises a sticky err on expiry. Without the
// macro the wait is unbounded and err is tied low.
//
// Ports
//   clk, rstb                      clock (falling edge), async active-low reset
//   w_valid / w_ready / w_data     weight stream in
//   s_valid / s_ready / s_data     sample stream in
//   r_valid / r_ready / r_data     result stream out
//   fir_wind, fir_load             shift strobes to the FIR (same cycle as handshake)
//   fir_in_valid                   compute strobe to the FIR (four cycles)
//   fir_data                       shift data to the FIR, 0 when no shift strobe
//   fir_out_valid, fir_out         FIR result in
//   busy                           high whenever the FSM is not idle
//   err                            sticky timeout flag
// -----------------------------------------------------------------------------
module fir_ctrl #(
  parameter int unsigned NTAPS = 16,
  parameter int unsigned TMO   = 15
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [15:0] w_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [15:0] r_data,
  output logic        fir_wind,
  output logic        fir_load,
  output logic        fir_in_valid,
  output logic [15:0] fir_data,
  input  logic        fir_out_valid,
  input  logic [15:0] fir_out,
  output logic        busy,
  output logic        err
);

  localparam int unsigned DW  = 16;
  localparam int unsigned TCW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int unsigned TMW = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam int unsigned FCW = 2;
  localparam int unsigned NFIRE = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WLOAD = 3'd1,
    DLOAD = 3'd2,
    FIRE  = 3'd3,
    WAIT  = 3'd4,
    HOLD  = 3'd5
  } state_e;

  state_e           state, state_nxt;
  logic [TCW-1:0]   tap_cnt, tap_cnt_nxt;
  logic [FCW-1:0]   fire_cnt, fire_cnt_nxt;
  logic [TMW-1:0]   tmo_cnt, tmo_cnt_nxt;
  logic             wok, wok_nxt;
  logic             primed, primed_nxt;
  logic [DW-1:0]    r_data_nxt;
  logic             w_hs, s_hs;
`ifdef FIR_CTRL_TIMEOUT_EN
  logic             tmo_hit;
`endif

  // Handshakes; readies are registered decodes of the state.
  assign w_hs = w_valid & w_ready;
  assign s_hs = s_valid & s_ready;

  // Shift strobes follow the handshake in the same cycle; data is zero otherwise.
  assign fir_wind = w_hs;
  assign fir_load = s_hs;
  assign fir_data = w_hs ? w_data : (s_hs ? s_data : DW'(0));

  // Next-state and next-counter logic.
  always_comb begin
    state_nxt    = state;
    tap_cnt_nxt  = tap_cnt;
    fire_cnt_nxt = fire_cnt;
    tmo_cnt_nxt  = tmo_cnt;
    wok_nxt      = wok;
    primed_nxt   = primed;
    r_data_nxt   = r_data;
`ifdef FIR_CTRL_TIMEOUT_EN
    tmo_hit      = 1'b0;
`endif

    case (state)
      IDLE: begin
        // Weights take priority over samples.
        if (w_valid) begin
          state_nxt = WLOAD;
          wok_nxt   = 1'b0;
        end else if (s_valid && wok) begin
          state_nxt = DLOAD;
        end
      end

      WLOAD: begin
        if (w_hs) begin
          tap_cnt_nxt = tap_cnt + TCW'(1);
          if (tap_cnt == TCW'(NTAPS - 1)) begin
            wok_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end

      DLOAD: begin
        // A primed window only needs the one newest sample.
        if (s_hs) begin
          tap_cnt_nxt = tap_cnt + TCW'(1);
          if (primed || (tap_cnt == TCW'(NTAPS - 1))) begin
            primed_nxt = 1'b1;
            state_nxt  = FIRE;
          end
        end
      end

      FIRE: begin
        fire_cnt_nxt = fire_cnt + FCW'(1);
        if (fire_cnt == FCW'(NFIRE - 1)) begin
          state_nxt = WAIT;
        end
      end

      WAIT: begin
        if (fir_out_valid) begin
          r_data_nxt = fir_out;
          state_nxt  = HOLD;
        end else begin
          if (tmo_cnt != TMW'(TMO)) begin
            tmo_cnt_nxt = tmo_cnt + TMW'(1);
          end
`ifdef FIR_CTRL_TIMEOUT_EN
          if (tmo_cnt == TMW'(TMO - 1)) begin
            tmo_hit   = 1'b1;
            state_nxt = IDLE;
          end
`endif
        end
      end

      HOLD: begin
        if (r_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Every state entry starts with fresh counters.
    if (state_nxt != state) begin
      tap_cnt_nxt  = '0;
      fire_cnt_nxt = '0;
      tmo_cnt_nxt  = '0;
    end
  end

  // State, flags, counters and registered outputs.
  always_ff @(negedge clk or negedge rstb) begin
    if (!rstb) begin
      state        <= IDLE;
      tap_cnt      <= '0;
      fire_cnt     <= '0;
      tmo_cnt      <= '0;
      wok          <= 1'b0;
      primed       <= 1'b0;
      w_ready      <= 1'b0;
      s_ready      <= 1'b0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      fir_in_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      tap_cnt      <= tap_cnt_nxt;
      fire_cnt     <= fire_cnt_nxt;
      tmo_cnt      <= tmo_cnt_nxt;
      wok          <= wok_nxt;
      primed       <= primed_nxt;
      w_ready      <= (state_nxt == WLOAD);
      s_ready      <= (state_nxt == DLOAD);
      r_valid      <= (state_nxt == HOLD);
      r_data       <= r_data_nxt;
      fir_in_valid <= (state_nxt == FIRE);
      busy         <= (state_nxt != IDLE);
    end
  end

`ifdef FIR_CTRL_TIMEOUT_EN
  // Sticky until reset.
  always_ff @(negedge clk or negedge rstb) begin
    if (!rstb) begin
      err <= 1'b0;
    end else if (tmo_hit) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

`ifndef SYNTHESIS
  // FIR control strobes are mutually exclusive.
  a_strobe_onehot: assert property (@(negedge clk) disable iff (!rstb)
    $onehot0({fir_wind, fir_load, fir_in_valid}));

  // Samples are only taken in DLOAD, which needs loaded weights.
  a_no_sample_without_weights: assert property (@(negedge clk) disable iff (!rstb)
    s_ready |-> wok);
`endif

endmodule

// File: tb/tb_fir_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fir_ctrl
// Randomised bench for fir_ctrl with a behavioural FIR engine and a reference
// model that keeps the loaded weights and the sample history as plain arrays
// and computes each expected result as a dot product over the last NTAPS
// samples. Inputs change just after the rising edge; the DUT and the FIR
// engine act on the falling edge; outputs are checked 1 ns after the rising
// edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fir_ctrl;

  localparam int NTAPS = 16;
  localparam int TMO   = 15;

  logic        clk, rstb;
  logic        w_valid, w_ready;
  logic [15:0] w_data;
  logic        s_valid, s_ready;
  logic [15:0] s_data;
  logic        r_valid, r_ready;
  logic [15:0] r_data;
  logic        fir_wind, fir_load, fir_in_valid;
  logic [15:0] fir_data;
  logic        fir_out_valid;
  logic [15:0] fir_out;
  logic        busy, err;

  fir_ctrl #(.NTAPS(NTAPS), .TMO(TMO)) dut (
    .clk           (clk),
    .rstb          (rstb),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .w_data        (w_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .r_valid       (r_valid),
    .r_ready       (r_ready),
    .r_data        (r_data),
    .fir_wind      (fir_wind),
    .fir_load      (fir_load),
    .fir_in_valid  (fir_in_valid),
    .fir_data      (fir_data),
    .fir_out_valid (fir_out_valid),
    .fir_out       (fir_out),
    .busy          (busy),
    .err           (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural FIR engine: two shift registers, dot product after the
  // four-cycle compute burst, result returned after a random latency.
  // ---------------------------------------------------------------------------
  logic [15:0] wsh [NTAPS];
  logic [15:0] dsh [NTAPS];
  int  wind_cnt   = 0;
  int  load_cnt   = 0;
  int  iv_run     = 0;
  int  last_run   = 0;
  int  lat_left   = 0;
  int  strobe_bad = 0;
  int  data_bad   = 0;
  bit  pend       = 1'b0;
  bit  stub_mute  = 1'b0;

  function automatic logic [15:0] stub_dot();
    int unsigned acc = 0;
    for (int k = 0; k < NTAPS; k++) acc += 32'(wsh[k]) * 32'(dsh[k]);
    return acc[15:0];
  endfunction

  always @(negedge clk or negedge rstb) begin
    if (!rstb) begin
      fir_out_valid <= 1'b0;
      fir_out       <= 16'd0;
      iv_run        <= 0;
      pend          <= 1'b0;
      lat_left      <= 0;
    end else begin
      fir_out_valid <= 1'b0;
      if ((32'(fir_wind) + 32'(fir_load) + 32'(fir_in_valid)) > 32'd1) strobe_bad <= strobe_bad + 1;
      if (!fir_wind && !fir_load && fir_data != 16'd0) data_bad <= data_bad + 1;
      if (fir_wind) begin
        wind_cnt <= wind_cnt + 1;
        for (int k = 0; k < NTAPS - 1; k++) wsh[k] <= wsh[k+1];
        wsh[NTAPS-1] <= fir_data;
      end
      if (fir_load) begin
        load_cnt <= load_cnt + 1;
        for (int k = 0; k < NTAPS - 1; k++) dsh[k] <= dsh[k+1];
        dsh[NTAPS-1] <= fir_data;
      end
      if (fir_in_valid) begin
        iv_run <= iv_run + 1;
        if (iv_run == 3) begin
          pend     <= 1'b1;
          lat_left <= int'($urandom_range(0, 3));
        end
      end else begin
        if (iv_run != 0) last_run <= iv_run;
        iv_run <= 0;
        if (pend) begin
          if (lat_left == 0) begin
            pend <= 1'b0;
            if (!stub_mute) begin
              fir_out_valid <= 1'b1;
              fir_out       <= stub_dot();
            end
          end else begin
            lat_left <= lat_left - 1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: loaded weights and sample history.
  // ---------------------------------------------------------------------------
  logic [15:0] mw [NTAPS];
  logic [15:0] mq [$];

  function automatic logic [15:0] model_result();
    int unsigned acc = 0;
    for (int k = 0; k < NTAPS; k++) acc += 32'(mw[k]) * 32'(mq[k]);
    return acc[15:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input bit is_w, input logic [15:0] d);
    int n;
    @(posedge clk);
    if (is_w) begin
      w_valid = 1'b1;
      w_data  = d;
    end else begin
      s_valid = 1'b1;
      s_data  = d;
    end
    #1;
    n = 0;
    while (!(is_w ? w_ready : s_ready) && n < 20) begin
      cyc();
      n++;
    end
    if (is_w) begin
      chk("w_ready_wait", 32'(n < 20), 32'd1);
      chk("fir_wind", 32'(fir_wind), 32'd1);
      chk("fir_data_w", 32'(fir_data), 32'(d));
    end else begin
      chk("s_ready_wait", 32'(n < 20), 32'd1);
      chk("fir_load", 32'(fir_load), 32'd1);
      chk("fir_data_s", 32'(fir_data), 32'(d));
    end
  endtask

  task automatic drop();
    @(posedge clk);
    w_valid = 1'b0;
    s_valid = 1'b0;
    #1;
  endtask

  task automatic load_weights(input bit ones);
    int w0;
    logic [15:0] d;
    w0 = wind_cnt;
    for (int k = 0; k < NTAPS; k++) begin
      d = ones ? 16'd1 : 16'($urandom);
      mw[k] = d;
      push_word(1'b1, d);
    end
    drop();
    chk("wind_pulses", 32'(wind_cnt - w0), 32'(NTAPS));
    chk("busy_after_wload", 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input bit ramp, input int base, input int hold, output logic [15:0] got);
    int need, l0, n;
    logic [15:0] d, exp;
    need = (mq.size() == NTAPS) ? 1 : NTAPS;
    l0   = load_cnt;
    for (int k = 0; k < need; k++) begin
      d = ramp ? 16'(base + k) : 16'($urandom);
      mq.push_back(d);
      if (mq.size() > NTAPS) void'(mq.pop_front());
      push_word(1'b0, d);
    end
    drop();
    chk("fire_start", 32'(fir_in_valid), 32'd1);
    exp = model_result();
    n = 0;
    while (!r_valid && n < 100) begin
      cyc();
      n++;
    end
    chk("r_valid_wait", 32'(n < 100), 32'd1);
    chk("load_pulses", 32'(load_cnt - l0), 32'(need));
    chk("fire_run", 32'(last_run), 32'd4);
    chk("r_data", 32'(r_data), 32'(exp));
    chk("s_ready_in_hold", 32'(s_ready), 32'd0);
    got = r_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      r_ready = 1'b0;
      s_valid = 1'($urandom_range(0, 1));
      w_valid = 1'($urandom_range(0, 1));
      #1;
      chk("hold_r_valid", 32'(r_valid), 32'd1);
      chk("hold_r_data", 32'(r_data), 32'(exp));
      chk("hold_no_accept", 32'({s_ready, w_ready, fir_load, fir_wind}), 32'd0);
    end
    @(posedge clk);
    s_valid = 1'b0;
    w_valid = 1'b0;
    r_ready = 1'b1;
    #1;
    chk("consume_r_valid", 32'(r_valid), 32'd1);
    @(posedge clk);
    r_ready = 1'b0;
    #1;
    chk("after_consume_r_valid", 32'(r_valid), 32'd0);
    chk("after_consume_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, 32'({w_ready, s_ready, r_valid, fir_wind, fir_load, fir_in_valid, busy, err}), 32'd0);
    chk(tag, 32'(r_data), 32'd0);
    chk(tag, 32'(fir_data), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] got;
    int bad;
    int n;

    rstb    = 1'b0;
    w_valid = 1'b0;
    w_data  = 16'd0;
    s_valid = 1'b0;
    s_data  = 16'd0;
    r_ready = 1'b0;
    for (int k = 0; k < NTAPS; k++) begin
      wsh[k] = 16'd0;
      dsh[k] = 16'd0;
    end
    repeat (3) cyc();
    check_all_zero("reset_outputs");
    @(posedge clk);
    rstb = 1'b1;
    #1;

    // Samples before any weights are never accepted.
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      s_valid = 1'b1;
      s_data  = 16'(c + 100);
      #1;
      if (s_ready || fir_load) bad++;
    end
    chk("no_weights_sample_refused", 32'(bad), 32'd0);
    chk("no_weights_busy", 32'(busy), 32'd0);
    drop();

    // Unit weights, ramp 1..16, then the sliding sample 17.
    load_weights(1'b1);
    run_frame(1'b1, 1, 10, got);
    chk("sum_1_to_16", 32'(got), 32'd136);
    run_frame(1'b1, 17, 2, got);
    chk("sum_2_to_17", 32'(got), 32'd152);

`ifdef FIR_CTRL_TIMEOUT_EN
    // FIR never answers: timeout after TMO cycles in WAIT.
    stub_mute = 1'b1;
    mq.push_back(16'd18);
    void'(mq.pop_front());
    push_word(1'b0, 16'd18);
    drop();
    chk("tmo_fire_start", 32'(fir_in_valid), 32'd1);
    n = 1;
    while (!err && n < 100) begin
      cyc();
      n++;
    end
    chk("tmo_latency", 32'(n), 32'(TMO + 5));
    chk("tmo_r_valid", 32'(r_valid), 32'd0);
    chk("tmo_busy", 32'(busy), 32'd0);
    repeat (3) cyc();
    stub_mute = 1'b0;
    chk("tmo_err_sticky", 32'(err), 32'd1);
`else
    n = 0;
`endif

    // Reset in the middle of the first window fill.
    load_weights(1'b0);
    mq.delete();
    // force an unprimed window: reset is the only way back to a full fill
    @(posedge clk);
    rstb = 1'b0;
    #1;
    check_all_zero("reset_idle_state");
    @(posedge clk);
    rstb = 1'b1;
    #1;
    load_weights(1'b0);
    for (int k = 0; k < 8; k++) push_word(1'b0, 16'($urandom));
    @(posedge clk);
    rstb = 1'b0;
    #1;
    check_all_zero("reset_mid_dload");
    @(posedge clk);
    rstb = 1'b1;
    #1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      s_valid = 1'b1;
      #1;
      if (s_ready || fir_load) bad++;
    end
    chk("post_reset_sample_refused", 32'(bad), 32'd0);
    drop();
    load_weights(1'b0);
    run_frame(1'b0, 0, 1, got);

    // Randomised traffic with occasional weight reloads.
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 2) == 0) load_weights(1'b0);
      run_frame(1'b0, 0, int'($urandom_range(0, 10)), got);
    end

    chk("strobe_overlap", 32'(strobe_bad), 32'd0);
    chk("idle_fir_data", 32'(data_bad), 32'd0);
    chk("err_final", 32'(err), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
